// File: rtl/fix_mul_arbiter_if.sv
// Requester-side bus of the shared fixed-point multiplier: operand handshake plus
// one-hot response strobe with a shared result/overflow.
interface fix_mul_arbiter_if #(
  parameter int DATA = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DATA-1:0] req_a;
  logic [NREQ*DATA-1:0] req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [DATA-1:0]      rsp_data;
  logic                 rsp_ovf;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_ovf
  );
endinterface

// File: rtl/fix_mul_arbiter.sv
// Round-robin front end for one pipelined sign-magnitude Q7.8 multiplier: issues one
// operand pair per cycle, tracks owners in a tag pipe, and truncates/saturates the product.
module fix_mul_arbiter #(
  parameter int DATA    = 16,
  parameter int INTE    = 7,
  parameter int POIN    = 8,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stop,
  output logic                  idle,
  output logic [DATA-1:0]       mul_in1,
  output logic [DATA-1:0]       mul_in2,
  input  logic [2*(DATA-1)-1:0] mul_prod,
  fix_mul_arbiter_if.slave      req_if
);

  localparam int MW  = DATA - 1;
  localparam int PRW = 2 * (DATA - 1);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     gnt_id;
  logic              gnt_any;
  logic [PW:0]       idx;
  logic [MUL_LAT:0]  tag_vld_p;
  logic [MUL_LAT:0]  tag_sgn_p;
  logic [PW-1:0]     tag_id_p [MUL_LAT+1];
  logic              pipe_empty;
  logic [MW:0]       rnd_mag;
  logic              op_sgn;

  // Magnitude truncation toward zero; anything above the Q7 integer range saturates.
  function automatic logic [MW:0] sat_mag(input logic [PRW-1:0] prod);
    logic          ovf;
    logic [MW-1:0] m;
    ovf = |prod[PRW-1:2*POIN+INTE];
    m   = ovf ? '1 : prod[2*POIN+INTE-1:POIN];
    return {ovf, m};
  endfunction

  assign pipe_empty       = ~|tag_vld_p;
  assign rnd_mag          = sat_mag(mul_prod);
  assign req_if.req_ready = grant;
  assign op_sgn = req_if.req_a[gnt_id*DATA + DATA-1] ^ req_if.req_b[gnt_id*DATA + DATA-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   if (!stop) state_nxt = RUN;
               else if (pipe_empty) state_nxt = HALT;
      HALT:    if (!stop) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Rotating search starting at ptr; only RUN may grant.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    idle    = (state == HALT);
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!gnt_any && (state == RUN) && req_if.req_valid[idx[PW-1:0]]) begin
        gnt_any           = 1'b1;
        gnt_id            = idx[PW-1:0];
        grant[idx[PW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      tag_vld_p <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[MUL_LAT-1:0], gnt_any};
      if (gnt_any) ptr <= (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stage p0: operands launched to the multiplier, tag enters the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_in1 <= '0;
      mul_in2 <= '0;
    end else if (gnt_any) begin
      mul_in1 <= {1'b0, req_if.req_a[gnt_id*DATA +: MW]};
      mul_in2 <= {1'b0, req_if.req_b[gnt_id*DATA +: MW]};
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p[0] <= gnt_id;
    tag_sgn_p   <= {tag_sgn_p[MUL_LAT-1:0], op_sgn};
    for (int i = 1; i <= MUL_LAT; i++) tag_id_p[i] <= tag_id_p[i-1];
  end

  // Stage p(MUL_LAT+1): product captured against its tag; -0 is folded to +0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_if.rsp_valid <= '0;
      req_if.rsp_data  <= '0;
      req_if.rsp_ovf   <= 1'b0;
    end else begin
      req_if.rsp_valid <= '0;
      if (tag_vld_p[MUL_LAT]) begin
        req_if.rsp_valid[tag_id_p[MUL_LAT]] <= 1'b1;
        req_if.rsp_data <= {tag_sgn_p[MUL_LAT] & (|rnd_mag[MW-1:0]), rnd_mag[MW-1:0]};
        req_if.rsp_ovf  <= rnd_mag[MW];
      end
    end
  end

endmodule

// File: tb/tb_fix_mul_arbiter.sv
// Directed bench for fix_mul_arbiter with a 3-stage behavioural multiplier model.
module tb_fix_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic        idle;
  logic [15:0] mul_in1, mul_in2;
  logic [29:0] mul_prod;
  logic [29:0] p1, p2, p3;

  int n_tests = 0;
  int n_fail  = 0;

  fix_mul_arbiter_if #(.DATA(16), .NREQ(4)) bus();

  fix_mul_arbiter #(.DATA(16), .INTE(7), .POIN(8), .NREQ(4), .MUL_LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .idle     (idle),
    .mul_in1  (mul_in1),
    .mul_in2  (mul_in2),
    .mul_prod (mul_prod),
    .req_if   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= 30'(mul_in1[14:0]) * 30'(mul_in2[14:0]);
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_prod = p3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        ovf;
  } vec_t;

  vec_t        tbl [10];
  int          lat;
  logic [3:0]  exp_rdy, exp_rsp;

  initial begin
    tbl[0] = '{0, 16'h0180, 16'h0200, 16'h0300, 1'b0};
    tbl[1] = '{2, 16'h8180, 16'h0200, 16'h8300, 1'b0};
    tbl[2] = '{2, 16'h8000, 16'h0100, 16'h0000, 1'b0};
    tbl[3] = '{1, 16'h6400, 16'h6400, 16'h7FFF, 1'b1};
    tbl[4] = '{1, 16'hE400, 16'h6400, 16'hFFFF, 1'b1};
    tbl[5] = '{3, 16'h0080, 16'h8080, 16'h8040, 1'b0};
    tbl[6] = '{3, 16'h8001, 16'h0001, 16'h0000, 1'b0};
    tbl[7] = '{0, 16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
    tbl[8] = '{0, 16'h4000, 16'h8200, 16'hFFFF, 1'b1};
    tbl[9] = '{1, 16'h0101, 16'h8101, 16'h8102, 1'b0};

    rst = 1'b1;
    stop = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    chk("reset mul_in1", 32'(mul_in1), 0);
    chk("reset mul_in2", 32'(mul_in2), 0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset rsp_data", 32'(bus.rsp_data), 0);
    chk("reset rsp_ovf", 32'(bus.rsp_ovf), 0);
    chk("reset idle", 32'(idle), 0);
    rst = 1'b0;
    @(negedge clk);

    // single operations, one requester at a time
    for (int v = 0; v < 10; v++) begin
      bus.req_valid = 4'(1 << tbl[v].idx);
      bus.req_a[tbl[v].idx*16 +: 16] = tbl[v].a;
      bus.req_b[tbl[v].idx*16 +: 16] = tbl[v].b;
      #1;
      chk($sformatf("v%0d ready", v), 32'(bus.req_ready), 32'(1 << tbl[v].idx));
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      chk($sformatf("v%0d mul_in1", v), 32'(mul_in1), 32'({1'b0, tbl[v].a[14:0]}));
      chk($sformatf("v%0d mul_in2", v), 32'(mul_in2), 32'({1'b0, tbl[v].b[14:0]}));
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (bus.rsp_valid == 4'b0 && lat < 10);
      chk($sformatf("v%0d latency", v), 32'(lat), 4);
      chk($sformatf("v%0d rsp_valid", v), 32'(bus.rsp_valid), 32'(1 << tbl[v].idx));
      chk($sformatf("v%0d rsp_data", v), 32'(bus.rsp_data), 32'(tbl[v].d));
      chk($sformatf("v%0d rsp_ovf", v), 32'(bus.rsp_ovf), 32'(tbl[v].ovf));
      @(negedge clk);
      chk($sformatf("v%0d pulse", v), 32'(bus.rsp_valid), 0);
    end

    // fairness from ptr=0 after a reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*16 +: 16] = 16'((i + 1) * 16'h0100);
      bus.req_b[i*16 +: 16] = 16'h0100;
    end
    for (int k = 0; k <= 13; k++) begin
      if (k == 0) bus.req_valid = '1;
      if (k == 8) bus.req_valid = '0;
      #1;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0;
      exp_rsp = (k >= 5 && k <= 12) ? 4'(1 << ((k - 5) % 4)) : 4'b0;
      chk($sformatf("rr%0d ready", k), 32'(bus.req_ready), 32'(exp_rdy));
      chk($sformatf("rr%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(exp_rsp));
      if (exp_rsp != 0)
        chk($sformatf("rr%0d rsp_data", k), 32'(bus.rsp_data), 32'(((k - 5) % 4 + 1) * 256));
      @(negedge clk);
    end

    // drain: stop arrives with the third grant
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) bus.req_valid = '1;
      if (k == 2) stop = 1'b1;
      if (k == 9) stop = 1'b0;
      #1;
      exp_rdy = (k <= 2) ? 4'(1 << k) : ((k == 10) ? 4'b1000 : 4'b0);
      exp_rsp = (k >= 5 && k <= 7) ? 4'(1 << (k - 5)) : 4'b0;
      chk($sformatf("dr%0d ready", k), 32'(bus.req_ready), 32'(exp_rdy));
      chk($sformatf("dr%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(exp_rsp));
      if (exp_rsp != 0)
        chk($sformatf("dr%0d rsp_data", k), 32'(bus.rsp_data), 32'((k - 4) * 256));
      chk($sformatf("dr%0d idle", k), 32'(idle), 32'(k == 8 || k == 9));
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("dr resume rsp_valid", 32'(bus.rsp_valid), 32'h8);
    chk("dr resume rsp_data", 32'(bus.rsp_data), 32'h0400);
    repeat (2) @(negedge clk);

    // reset with two products in flight
    bus.req_valid = 4'b0011;
    #1;
    chk("rs grant0", 32'(bus.req_ready), 1);
    @(negedge clk);
    chk("rs grant1", 32'(bus.req_ready), 2);
    @(negedge clk);
    bus.req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("rs mul_in1", 32'(mul_in1), 0);
    chk("rs mul_in2", 32'(mul_in2), 0);
    chk("rs rsp_data", 32'(bus.rsp_data), 0);
    chk("rs rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rs idle", 32'(idle), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rs quiet%0d", k), 32'(bus.rsp_valid), 0);
    end
    bus.req_valid = '1;
    #1;
    chk("rs ptr0", 32'(bus.req_ready), 1);
    bus.req_valid = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
